// File: rtl/mux_2_1_arb.sv
// Round-robin arbiter driving a shared 2:1 packet mux with valid/ready flow.
// Optional idle watchdog enabled by defining MUX_ARB_TIMEOUT_EN.
module mux_2_1_arb #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              in_0_valid,
    input  logic [DATA_W-1:0] in_0_data,
    input  logic              in_0_last,
    output logic              in_0_ready,
    input  logic              in_1_valid,
    input  logic [DATA_W-1:0] in_1_data,
    input  logic              in_1_last,
    output logic              in_1_ready,
    output logic              out_0_valid,
    output logic [DATA_W-1:0] out_0_data,
    output logic              out_0_last,
    input  logic              out_0_ready,
    output logic              sel_0,
    output logic              busy,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_0 = 2'd1,
        GRANT_1 = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   prio, prio_nxt;
    logic   eop;
    logic   tmo;

    always_comb begin
        out_0_valid = 1'b0;
        out_0_data  = '0;
        out_0_last  = 1'b0;
        in_0_ready  = 1'b0;
        in_1_ready  = 1'b0;
        unique case (state)
            GRANT_0: begin
                out_0_valid = in_0_valid;
                out_0_data  = in_0_data;
                out_0_last  = in_0_last;
                in_0_ready  = out_0_ready;
            end
            GRANT_1: begin
                out_0_valid = in_1_valid;
                out_0_data  = in_1_data;
                out_0_last  = in_1_last;
                in_1_ready  = out_0_ready;
            end
            default: ;
        endcase
    end

    assign eop   = out_0_valid & out_0_ready & out_0_last;
    assign sel_0 = (state == GRANT_1);
    assign busy  = (state != IDLE);

`ifdef MUX_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    assign tmo = busy && !out_0_valid && (cnt == CW'(TIMEOUT - 1));

    // Counts consecutive granted cycles in which the owner shows no beat.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= tmo;
            if (!busy || out_0_valid || state_nxt != state)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT;

    assign tmo         = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        prio_nxt  = prio;
        unique case (state)
            IDLE: begin
                if (in_0_valid && (!in_1_valid || !prio))
                    state_nxt = GRANT_0;
                else if (in_1_valid)
                    state_nxt = GRANT_1;
            end
            GRANT_0: begin
                if (tmo) begin
                    state_nxt = IDLE;
                    prio_nxt  = 1'b1;
                end else if (eop) begin
                    prio_nxt = 1'b1;
                    if (in_1_valid)
                        state_nxt = GRANT_1;
                    else if (in_0_valid)
                        state_nxt = GRANT_0;
                    else
                        state_nxt = IDLE;
                end
            end
            GRANT_1: begin
                if (tmo) begin
                    state_nxt = IDLE;
                    prio_nxt  = 1'b0;
                end else if (eop) begin
                    prio_nxt = 1'b0;
                    if (in_0_valid)
                        state_nxt = GRANT_0;
                    else if (in_1_valid)
                        state_nxt = GRANT_1;
                    else
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= IDLE;
            prio  <= 1'b0;
        end else begin
            state <= state_nxt;
            prio  <= prio_nxt;
        end
    end

endmodule

// File: tb/tb_mux_2_1_arb.sv
// Directed self-checking bench for mux_2_1_arb (TIMEOUT = 4).
// Watchdog steps depend on whether MUX_ARB_TIMEOUT_EN is defined.
module tb_mux_2_1_arb;

    localparam int DW = 8;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          in_0_valid = 1'b0;
    logic [DW-1:0] in_0_data = '0;
    logic          in_0_last = 1'b0;
    logic          in_0_ready;
    logic          in_1_valid = 1'b0;
    logic [DW-1:0] in_1_data = '0;
    logic          in_1_last = 1'b0;
    logic          in_1_ready;
    logic          out_0_valid;
    logic [DW-1:0] out_0_data;
    logic          out_0_last;
    logic          out_0_ready = 1'b0;
    logic          sel_0;
    logic          busy;
    logic          timeout_err;

    int total = 0;
    int bad   = 0;

    mux_2_1_arb #(.DATA_W(DW), .TIMEOUT(4)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .in_0_valid (in_0_valid),
        .in_0_data  (in_0_data),
        .in_0_last  (in_0_last),
        .in_0_ready (in_0_ready),
        .in_1_valid (in_1_valid),
        .in_1_data  (in_1_data),
        .in_1_last  (in_1_last),
        .in_1_ready (in_1_ready),
        .out_0_valid(out_0_valid),
        .out_0_data (out_0_data),
        .out_0_last (out_0_last),
        .out_0_ready(out_0_ready),
        .sel_0      (sel_0),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst     = 1'b1;
        in_0_valid  = 1'b0;
        in_0_data   = '0;
        in_0_last   = 1'b0;
        in_1_valid  = 1'b0;
        in_1_data   = '0;
        in_1_last   = 1'b0;
        out_0_ready = 1'b0;
        @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    logic       e1_sel [8] = '{0, 0, 0, 0, 1, 1, 1, 0};
    logic       e1_bsy [8] = '{0, 1, 1, 1, 1, 1, 1, 1};
    logic [7:0] e1_dat [8] = '{8'h00, 8'h10, 8'h11, 8'h12,
                               8'h20, 8'h21, 8'h22, 8'h13};
    logic [7:0] s2_dat [3] = '{8'hA1, 8'hA2, 8'hB1};
    logic       s2_lst [3] = '{0, 1, 1};
    logic       e2_val [5] = '{0, 1, 1, 1, 0};
    logic [7:0] e2_dat [5] = '{8'h00, 8'hA1, 8'hA2, 8'hB1, 8'h00};
    logic       e2_bsy [5] = '{0, 1, 1, 1, 1};

    initial begin
        int b0, b1, n;
        int viol;

        // reset state
        @(negedge sys_clk);
        #1;
        chk("rst_sel", sel_0, 0);
        chk("rst_busy", busy, 0);
        chk("rst_oval", out_0_valid, 0);
        chk("rst_rdy0", in_0_ready, 0);
        chk("rst_rdy1", in_1_ready, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_odat", out_0_data, 0);
        @(negedge sys_clk);
        sys_rst = 1'b0;

        // both sources, 3-beat packets, alternating grant
        b0 = 0;
        b1 = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge sys_clk);
            in_0_valid  = 1'b1;
            in_0_data   = 8'h10 + b0[7:0];
            in_0_last   = (b0 % 3 == 2);
            in_1_valid  = 1'b1;
            in_1_data   = 8'h20 + b1[7:0];
            in_1_last   = (b1 % 3 == 2);
            out_0_ready = 1'b1;
            #1;
            chk($sformatf("t1_sel%0d", c), sel_0, e1_sel[c]);
            chk($sformatf("t1_busy%0d", c), busy, e1_bsy[c]);
            chk($sformatf("t1_dat%0d", c), out_0_data, e1_dat[c]);
            if (in_0_valid && in_0_ready) b0++;
            if (in_1_valid && in_1_ready) b1++;
        end

        // only in_1: two packets back-to-back
        do_reset();
        n = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge sys_clk);
            out_0_ready = 1'b1;
            in_1_valid  = (n < 3);
            in_1_data   = (n < 3) ? s2_dat[n] : 8'h00;
            in_1_last   = (n < 3) ? s2_lst[n] : 1'b0;
            #1;
            chk($sformatf("t2_val%0d", c), out_0_valid, e2_val[c]);
            chk($sformatf("t2_dat%0d", c), out_0_data, e2_dat[c]);
            chk($sformatf("t2_busy%0d", c), busy, e2_bsy[c]);
            chk($sformatf("t2_sel%0d", c), sel_0, e2_bsy[c]);
            chk($sformatf("t2_rdy0_%0d", c), in_0_ready, 0);
            if (in_1_valid && in_1_ready) n++;
        end

        // ready toggling on a 4-beat in_0 packet with in_1 waiting
        do_reset();
        b0 = 0;
        n  = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge sys_clk);
            in_0_valid  = (b0 < 4);
            in_0_data   = 8'h30 + b0[7:0];
            in_0_last   = (b0 == 3);
            in_1_valid  = 1'b1;
            in_1_data   = 8'hEE;
            in_1_last   = 1'b1;
            out_0_ready = c[0];
            #1;
            if (c > 0) begin
                chk($sformatf("t3_busy%0d", c), busy, 1);
                chk($sformatf("t3_sel%0d", c), sel_0, 0);
                chk($sformatf("t3_rdy1_%0d", c), in_1_ready, 0);
                chk($sformatf("t3_hs%0d", c),
                    out_0_valid && out_0_ready, c[0]);
            end
            if (out_0_valid && out_0_ready) begin
                chk($sformatf("t3_dat%0d", n), out_0_data, 8'h30 + n);
                n++;
            end
            if (in_0_valid && in_0_ready) b0++;
        end
        chk("t3_count", n, 4);
        @(negedge sys_clk);
        in_0_valid  = 1'b0;
        out_0_ready = 1'b1;
        #1;
        chk("t3_next_sel", sel_0, 1);
        chk("t3_next_dat", out_0_data, 8'hEE);

        // asynchronous reset while in GRANT_1
        do_reset();
        @(negedge sys_clk);
        in_1_valid  = 1'b1;
        in_1_data   = 8'h51;
        in_1_last   = 1'b0;
        out_0_ready = 1'b1;
        @(negedge sys_clk);
        #1;
        chk("t4_sel_pre", sel_0, 1);
        chk("t4_rdy1_pre", in_1_ready, 1);
        #2;
        sys_rst = 1'b1;
        #1;
        chk("t4_sel", sel_0, 0);
        chk("t4_busy", busy, 0);
        chk("t4_oval", out_0_valid, 0);
        chk("t4_rdy0", in_0_ready, 0);
        chk("t4_rdy1", in_1_ready, 0);
        @(negedge sys_clk);
        sys_rst    = 1'b0;
        in_0_valid = 1'b1;
        in_0_data  = 8'h61;
        in_0_last  = 1'b1;
        in_1_data  = 8'h52;
        #1;
        chk("t4_idle", busy, 0);
        @(negedge sys_clk);
        #1;
        chk("t4_win_sel", sel_0, 0);
        chk("t4_win_dat", out_0_data, 8'h61);

        // watchdog: one beat without last, then silence
        do_reset();
        @(negedge sys_clk);
        in_0_valid  = 1'b1;
        in_0_data   = 8'h40;
        in_0_last   = 1'b0;
        out_0_ready = 1'b1;
        @(negedge sys_clk);
        #1;
        chk("t5_beat", out_0_valid && in_0_ready, 1);
`ifdef MUX_ARB_TIMEOUT_EN
        for (int c = 2; c < 8; c++) begin
            @(negedge sys_clk);
            in_0_valid = 1'b0;
            in_1_valid = 1'b1;
            in_1_data  = 8'h77;
            in_1_last  = 1'b1;
            #1;
            chk($sformatf("t5_busy%0d", c), busy, (c != 6));
            chk($sformatf("t5_terr%0d", c), timeout_err, (c == 6));
            chk($sformatf("t5_sel%0d", c), sel_0, (c == 7));
        end
`else
        viol = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge sys_clk);
            in_0_valid = 1'b0;
            in_1_valid = 1'b1;
            in_1_data  = 8'h77;
            in_1_last  = 1'b1;
            #1;
            if (!busy || sel_0 || timeout_err) viol++;
        end
        chk("t5_hold_viol", viol, 0);
        chk("t5_hold_sel", sel_0, 0);
        chk("t5_hold_terr", timeout_err, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_2_1_arb.md
# mux_2_1_arb

Two-requester round-robin arbiter that shares one 2:1 mux output channel between streaming sources `in_0` and `in_1`. The block owns the mux select. It holds a grant for a whole packet (until the `last` beat is accepted) and alternates priority between packets. It sits between two packet sources and a single downstream consumer with valid/ready flow control.

## Interface

**Parameters**
- `DATA_W`, default 8: data width of all channels.
- `TIMEOUT`, default 16: idle-cycle limit for the watchdog. Used only when `MUX_ARB_TIMEOUT_EN` is defined. Must be ≥ 2.

**Ports**
- `sys_clk`  in  1  single clock, rising edge.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `in_0_valid`  in  1  source 0 beat valid.
- `in_0_data`  in  DATA_W  source 0 beat data.
- `in_0_last`  in  1  source 0 final beat of packet.
- `in_0_ready`  out  1  source 0 beat accepted when high with `in_0_valid`.
- `in_1_valid`, `in_1_data`, `in_1_last`, `in_1_ready`: same as source 0, for source 1.
- `out_0_valid`  out  1  output beat valid.
- `out_0_data`  out  DATA_W  output beat data.
- `out_0_last`  out  1  output final beat.
- `out_0_ready`  in  1  downstream accepts beat.
- `sel_0`  out  1  current mux select (1 = source 1 granted).
- `busy`  out  1  a grant is held (state ≠ IDLE).
- `timeout_err`  out  1  one-cycle pulse when the watchdog revokes a grant.

## Operation

- **FSM states:** IDLE, GRANT_0, GRANT_1. Grant and priority are registers; the datapath is combinational.
- **Priority register `prio`:** 0 = source 0 preferred. Reset value 0.
- **IDLE:**
  - Only `in_0_valid` → GRANT_0 next cycle.
  - Only `in_1_valid` → GRANT_1 next cycle.
  - Both valid → grant the source indicated by `prio`.
  - Neither valid → stay in IDLE.
- **GRANT_x datapath:**
  - `out_0_valid` = `in_x_valid`, `out_0_data` = `in_x_data`, `out_0_last` = `in_x_last`.
  - `in_x_ready` = `out_0_ready`; the other source's ready = 0.
- **End of packet:** a handshake (`in_x_valid & out_0_ready`) with `in_x_last` = 1 ends the packet. On that edge:
  - `prio` ← the other source.
  - Next state is arbitrated immediately, with no IDLE bubble:
    - other source valid → GRANT_other;
    - else same source valid → GRANT_x;
    - else → IDLE.
- **Mid-packet:** `in_x_valid` dropping to 0 does not release the grant.
- **Non-granted source:** its `valid`/`data` are ignored and its ready is held 0.
- **Outputs:**
  - `sel_0` = 1 only in GRANT_1, else 0.
  - `busy` = 1 in GRANT_0/GRANT_1.
  - In IDLE: `out_0_valid` = 0, `out_0_data` = 0, `out_0_last` = 0, and both readies = 0.
- **Reset values:** all outputs 0; state IDLE; `prio` 0.
- **Reset mid-packet:** asynchronous reset forces IDLE immediately. The partial packet is abandoned and no recovery is attempted.

## Timing

- Request to grant: 1 cycle. A valid source sampled in IDLE at edge N is granted after edge N. Its first beat can transfer in cycle N+1.
- Back-to-back packets: the next packet's first beat can transfer in the cycle after the `last` handshake.
- Throughput under a grant is 1 beat/cycle. The datapath adds zero latency.
- Ready is combinational from `out_0_ready`; there is no combinational path from `valid` to `ready`.
- Single-beat packet (`last` = 1 on the first beat): the grant lasts exactly 1 cycle when `out_0_ready` = 1.

## Configuration

- **`MUX_ARB_TIMEOUT_EN` defined:**
  - A counter counts consecutive granted cycles with `in_x_valid` = 0.
  - The counter clears on any granted-source valid and on every grant change.
  - When the count reaches `TIMEOUT`:
    - the FSM goes to IDLE;
    - `prio` ← the other source;
    - `timeout_err` pulses high for 1 cycle.
- **`MUX_ARB_TIMEOUT_EN` undefined:**
  - No counter is built.
  - `timeout_err` is tied to 0.
  - A grant is held until the `last` handshake, indefinitely if necessary.

## Test plan

- Reset, then both sources valid with 3-beat packets and `out_0_ready` = 1 → order is in_0 (3 beats), in_1 (3 beats), in_0 …; `sel_0` toggles 0→1→0 with no idle cycle.
- Only in_1 sends 2 packets (data 0xA1, 0xA2 last; 0xB1 last) → both granted back-to-back; `in_0_ready` stays 0 throughout.
- `out_0_ready` toggles 1/0 every cycle during a 4-beat packet → exactly 4 handshakes, data in order, grant held across stalls.
- Assert `sys_rst` asynchronously mid-packet in GRANT_1 → `sel_0`, `busy`, `out_0_valid` and both readies go 0 immediately; after release, in_0 wins a simultaneous request.
- Macro defined, `TIMEOUT` = 4: in_0 sends 1 beat (no last), then holds valid low → after 4 cycles, state is IDLE, `timeout_err` is a 1-cycle pulse, and a pending in_1 is granted next.
- Macro undefined, same stimulus → grant held for 100 cycles, `timeout_err` never 1.
